// File: rtl/fre_sched_pkg.sv
// Shared state encoding and width helpers for the frequency-judge scheduler.
package fre_sched_pkg;

   localparam logic [5:0] ST_IDLE   = 6'b000001;
   localparam logic [5:0] ST_SETTLE = 6'b000010;
   localparam logic [5:0] ST_START  = 6'b000100;
   localparam logic [5:0] ST_WAIT   = 6'b001000;
   localparam logic [5:0] ST_STORE  = 6'b010000;
   localparam logic [5:0] ST_ABORT  = 6'b100000;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (longint unsigned p = 1; p < longint'(v); p = p << 1) r++;
      return r;
   endfunction

   // Channel index width; never narrower than one bit.
   function automatic int unsigned ch_w(input int unsigned n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/fre_judge_sched_rr_arbiter.sv
// Combinational round-robin pick: first pending channel at or after ptr, wrapping.
module rr_arbiter
   import fre_sched_pkg::*;
#(
   parameter  int unsigned NUM_CH = 4,
   localparam int unsigned CH_W   = ch_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] pend,
   input  logic [CH_W-1:0]   ptr,
   output logic              grant_vld,
   output logic [CH_W-1:0]   grant_idx
);

   always_comb begin
      logic [CH_W-1:0] idx;
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         idx = CH_W'((32'(ptr) + i) % NUM_CH);
         if (!grant_vld && pend[idx]) begin
            grant_vld = 1'b1;
            grant_idx = idx;
         end
      end
   end

endmodule

// File: rtl/fre_judge_sched.sv
// Shares one frequency-judge engine between NUM_CH channels, served round-robin.
// Define FRE_SCHED_AVG_EN to store the running average of successive results.
module fre_judge_sched
   import fre_sched_pkg::*;
#(
   parameter  int unsigned NUM_CH      = 4,
   parameter  int unsigned INPUT_WIDTH = 16,
   parameter  int unsigned OUT_WIDTH   = 14,
   parameter  int unsigned SETTLE_CYC  = 16,
   parameter  int unsigned TMO_CYC     = 2000000,
   parameter  int unsigned RST_CYC     = 4,
   localparam int unsigned CH_W        = ch_w(NUM_CH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             req,
   input  logic [NUM_CH*INPUT_WIDTH-1:0] dat_in,
   output logic [INPUT_WIDTH-1:0]        eng_dat,
   output logic                          eng_start,
   input  logic [OUT_WIDTH-1:0]          eng_fre,
   input  logic                          eng_dready,
   output logic                          eng_rst,
   output logic [NUM_CH*OUT_WIDTH-1:0]   fre_out,
   output logic [NUM_CH-1:0]             fre_vld,
   output logic [NUM_CH-1:0]             fre_tmo,
   output logic                          busy,
   output logic [CH_W-1:0]               cur_ch
);

   localparam int unsigned CNT_MAX = (SETTLE_CYC > RST_CYC) ? SETTLE_CYC : RST_CYC;
   localparam int unsigned CW      = ch_w(CNT_MAX);
   localparam int unsigned TW      = clog2(TMO_CYC + 1);

   logic [5:0]           state;
   logic [CH_W-1:0]      ptr;
   logic [CH_W-1:0]      ptr_nxt;
   logic [NUM_CH-1:0]    pend;
   logic [NUM_CH-1:0]    pend_n;
   logic [NUM_CH-1:0]    ch_onehot;
   logic [CW-1:0]        cnt;
   logic [TW-1:0]        tmo_cnt;
   logic                 tmo_hit;
   logic                 grant_vld;
   logic [CH_W-1:0]      grant_idx;
   logic [OUT_WIDTH-1:0] wr_val;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .pend      (pend),
      .ptr       (ptr),
      .grant_vld (grant_vld),
      .grant_idx (grant_idx)
   );

   assign busy      = (state != ST_IDLE);
   assign eng_start = (state == ST_START);
   assign eng_rst   = (state == ST_ABORT);
   assign ch_onehot = NUM_CH'(1) << cur_ch;
   assign ptr_nxt   = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + CH_W'(1);
   assign tmo_hit   = (tmo_cnt == TW'(TMO_CYC - 1));

   // Clear happens on entry to STORE/ABORT; OR-ing req afterwards lets a new request win.
   always_comb begin
      pend_n = pend;
      if (state == ST_WAIT && (eng_dready || tmo_hit)) pend_n[cur_ch] = 1'b0;
      pend_n = pend_n | req;
   end

`ifdef FRE_SCHED_AVG_EN
   logic [NUM_CH-1:0]  primed;
   logic [OUT_WIDTH:0] avg_sum;

   always_comb begin
      avg_sum = {1'b0, fre_out[cur_ch*OUT_WIDTH +: OUT_WIDTH]} + {1'b0, eng_fre};
      wr_val  = primed[cur_ch] ? OUT_WIDTH'(avg_sum >> 1) : eng_fre;
   end

   // A timeout un-primes the channel so its next result is taken raw.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         primed <= '0;
      end else if (state == ST_WAIT) begin
         if (eng_dready)   primed[cur_ch] <= 1'b1;
         else if (tmo_hit) primed[cur_ch] <= 1'b0;
      end
   end
`else
   assign wr_val = eng_fre;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cur_ch  <= '0;
         ptr     <= '0;
         pend    <= '0;
         cnt     <= '0;
         tmo_cnt <= '0;
         eng_dat <= '0;
         fre_out <= '0;
         fre_vld <= '0;
         fre_tmo <= '0;
      end else begin
         eng_dat <= dat_in[cur_ch*INPUT_WIDTH +: INPUT_WIDTH];
         pend    <= pend_n;
         fre_vld <= '0;
         fre_tmo <= '0;
         case (state)
            ST_IDLE: begin
               if (grant_vld) begin
                  cur_ch <= grant_idx;
                  cnt    <= '0;
                  state  <= (SETTLE_CYC == 0) ? ST_START : ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt == CW'(SETTLE_CYC - 1)) state <= ST_START;
               else                            cnt   <= cnt + CW'(1);
            end
            ST_START: begin
               tmo_cnt <= '0;
               state   <= ST_WAIT;
            end
            ST_WAIT: begin
               // Result and fre_vld land together on entry to STORE.
               if (eng_dready) begin
                  fre_out[cur_ch*OUT_WIDTH +: OUT_WIDTH] <= wr_val;
                  fre_vld <= ch_onehot;
                  state   <= ST_STORE;
               end else if (tmo_hit) begin
                  fre_tmo <= ch_onehot;
                  cnt     <= '0;
                  state   <= ST_ABORT;
               end else if (tmo_cnt != '1) begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            ST_STORE: begin
               ptr   <= ptr_nxt;
               state <= ST_IDLE;
            end
            ST_ABORT: begin
               if (cnt == CW'(RST_CYC - 1)) begin
                  ptr   <= ptr_nxt;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/fre_judge_sched.md
Name: fre_judge_sched

Overview:
Shares one frequency-judge engine (mean → square judge → max-limit pipeline, start/dready handshake) between NUM_CH analog input channels. Measurement requests are served round-robin. For each grant the block:
- steers the selected channel's samples into the engine,
- lets the mux settle, then pulses the engine start,
- waits for the engine's dready, with a timeout,
- latches the result into a per-channel register.
It sits between the ADC front-end channels and the demodulation-mode decision logic.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
INPUT_WIDTH, 16, sample width per channel (signed)
OUT_WIDTH, 14, engine frequency-count width
SETTLE_CYC, 16, cycles eng_dat is held on the new channel before eng_start
TMO_CYC, 2000000, max cycles from eng_start to eng_dready before abort
RST_CYC, 4, length of eng_rst pulse after an abort

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req  in  NUM_CH  per-channel measurement request, single-cycle pulse or level
dat_in  in  NUM_CH*INPUT_WIDTH  channel samples, ch0 in LSBs
eng_dat  out  INPUT_WIDTH  registered sample to engine
eng_start  out  1  one-cycle engine start pulse
eng_fre  in  OUT_WIDTH  engine result
eng_dready  in  1  engine result-valid pulse
eng_rst  out  1  active-high engine reset, driven after timeout
fre_out  out  NUM_CH*OUT_WIDTH  latched per-channel result
fre_vld  out  NUM_CH  one-cycle pulse when a channel's fre_out updates
fre_tmo  out  NUM_CH  one-cycle pulse when a channel's measurement times out
busy  out  1  high in any state other than IDLE
cur_ch  out  CH_W  channel currently granted; CH_W = max(1, clog2(NUM_CH))

Behaviour:
Reset values:
- All outputs are 0.
- Pending bits are 0, rr pointer is 0, all counters are 0.

Pending bits:
- pend[i] is set when req[i] is high.
- pend[i] is cleared on entry to STORE or ABORT for the granted channel.
- If set and clear occur in the same cycle, set wins: the channel is re-queued.

Datapath:
- eng_dat <= dat_in slice[cur_ch] every cycle, giving 1-cycle register latency.

FSM states: IDLE, SETTLE, START, WAIT, STORE, ABORT.
- IDLE:
  - If any pend bit is set, grant the first set bit at or after ptr (wrapping).
  - Load cur_ch and go to SETTLE.
  - eng_dready is ignored in IDLE.
- SETTLE:
  - Count SETTLE_CYC cycles, then go to START.
  - SETTLE_CYC=0 goes straight to START.
- START:
  - eng_start=1 for exactly 1 cycle.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - If eng_dready is seen, capture eng_fre and go to STORE.
  - If the timeout counter reaches TMO_CYC-1 without eng_dready, go to ABORT.
  - If eng_dready and timeout coincide, dready wins.
- STORE:
  - Write fre_out[cur_ch] and pulse fre_vld[cur_ch].
  - ptr <= cur_ch+1 mod NUM_CH; go to IDLE.
- ABORT:
  - Drive eng_rst high for RST_CYC cycles.
  - Pulse fre_tmo[cur_ch] in the first ABORT cycle.
  - fre_out[cur_ch] keeps its previous value.
  - Advance ptr as in STORE, then go to IDLE.

Timing and fairness:
- Minimum request-to-start latency from IDLE: 1 + SETTLE_CYC + 1 cycles.
- Back-to-back requests get one IDLE cycle between grants.
- No channel waits more than NUM_CH-1 grants.

Other rules:
- cur_ch is stable from SETTLE through STORE/ABORT.
- Asserting rst mid-measurement returns to IDLE immediately and drops eng_start/eng_rst.
- After a mid-measurement reset, the engine may still complete; its dready then arrives in IDLE and is ignored.
- Timeout counter width is clog2(TMO_CYC+1); it saturates and never wraps.

Optional Feature:
FRE_SCHED_AVG_EN:
- When defined, STORE writes fre_out[ch] <= (fre_out[ch] + eng_fre) >> 1, using an OUT_WIDTH+1-bit sum.
- On a channel's first valid result after reset, or its first after a timeout, the raw eng_fre is stored instead. A per-channel "primed" bit tracks this.
- When undefined, STORE writes the raw eng_fre and the primed bits are not built.

Decomposition:
- Shared package fre_sched_pkg holds:
  - state encoding, one-hot, 6 bits, consistent with the engine FSMs;
  - the clog2 constant function;
  - the CH_W derivation.
- One sub-module, rr_arbiter (NUM_CH): inputs pend and ptr; outputs grant_vld and grant_idx; purely combinational priority rotate.
- The FSM, counters and result registers stay in fre_judge_sched.

Test Plan:
- Single request, NUM_CH=4, SETTLE_CYC=16: req[2] pulse.
  → eng_start exactly 18 cycles later.
  → Bench engine returns dready with eng_fre=1234 after 100 cycles.
  → fre_out[2]=1234, fre_vld[2] single pulse, busy drops the next cycle.
- All four req pulsed in the same cycle, ptr=0 → grants in order 0,1,2,3; each result lands only in its own slot.
- req[1] held high while channel 1 is served → channel 1 is re-granted only after channels 2, 3 and 0 if those are pending (fairness); otherwise immediately.
- Engine never answers, TMO_CYC=1000 → ABORT 1000 cycles after eng_start.
  → eng_rst high for 4 cycles, fre_tmo pulse, fre_out unchanged.
  → The next pending channel is served normally.
- eng_dready on the same cycle as the timeout → STORE taken, no fre_tmo. Also: rst asserted during WAIT, then a late eng_dready → no fre_vld, state IDLE.
- With FRE_SCHED_AVG_EN: results 1000 then 1200 on channel 0 → fre_out[0]=1000, then 1100.
